rob_multi_ins_queue: RTL

ROB_MULTI_INS_QUEUE -- requirements
Module: rob_multi_ins_queue

---
 rtl/rob_multi_ins_queue_pkg.sv | 9 +
 rtl/rob_multi_ins_queue_ctrl.sv | 75 +++++++
 rtl/rob_multi_ins_queue_dpath.sv | 37 +++
 rtl/rob_multi_ins_queue.sv | 63 ++++++
 4 files changed

// File: rtl/rob_multi_ins_queue_pkg.sv
// Shared definitions for the multi-insert reorder queue: default geometry
// used as parameter defaults by the queue top level.
package rob_multi_ins_queue_pkg;

  localparam int ROB_DEPTH    = 8;
  localparam int ROB_BITWIDTH = 32;
  localparam int ROB_NUM_INS  = 2;

endpackage

// File: rtl/rob_multi_ins_queue_ctrl.sv
// Control half of the reorder queue: insert arbitration, occupancy bits,
// head pointer and occupied-entry count.
module rob_MultiInsCtrlUnit #(
  parameter int p_depth    = 8,
  parameter int p_num_ins  = 2,
  parameter int p_ptrwidth = $clog2(p_depth)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic                            i_deq_en,
  input  logic [p_num_ins-1:0]            i_ins_en,
  input  logic [p_num_ins*p_ptrwidth-1:0] i_ins_sn,
  output logic [p_num_ins-1:0]            o_ins_cpl,
  output logic                            o_deq_cpl,
  output logic [p_ptrwidth-1:0]           o_head,
  output logic [p_ptrwidth:0]             o_occ_count
);

  logic [p_depth-1:0]    r_occ;
  logic [p_ptrwidth-1:0] r_head;
  logic [p_ptrwidth:0]   r_count;

  logic [p_depth-1:0]    w_occ_next;
  logic [p_num_ins-1:0]  w_ins_cpl;
  logic [p_ptrwidth:0]   w_ins_cnt;
  logic                  w_deq;

  // A port wins only if its slot is free and no lower-indexed port targets it;
  // the head slot stays occupied during its own dequeue cycle, so it is refused.
  always_comb begin
    w_ins_cpl  = '0;
    w_ins_cnt  = '0;
    w_deq      = i_deq_en & r_occ[r_head] & ~i_flush;
    w_occ_next = r_occ;
    for (int i = 0; i < p_num_ins; i++) begin
      w_ins_cpl[i] = i_ins_en[i] & ~i_flush & ~r_occ[i_ins_sn[i*p_ptrwidth +: p_ptrwidth]];
      for (int j = 0; j < i; j++) begin
        if (i_ins_en[j] &&
            (i_ins_sn[j*p_ptrwidth +: p_ptrwidth] == i_ins_sn[i*p_ptrwidth +: p_ptrwidth]))
          w_ins_cpl[i] = 1'b0;
      end
    end
    if (w_deq)
      w_occ_next[r_head] = 1'b0;
    for (int i = 0; i < p_num_ins; i++) begin
      if (w_ins_cpl[i])
        w_occ_next[i_ins_sn[i*p_ptrwidth +: p_ptrwidth]] = 1'b1;
      w_ins_cnt = w_ins_cnt + (p_ptrwidth+1)'(w_ins_cpl[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ   <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_occ   <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else begin
      r_occ   <= w_occ_next;
      r_count <= r_count + w_ins_cnt - (p_ptrwidth+1)'(w_deq);
      if (w_deq)
        r_head <= r_head + p_ptrwidth'(1);
    end
  end

  assign o_ins_cpl   = w_ins_cpl;
  assign o_deq_cpl   = r_occ[r_head];
  assign o_head      = r_head;
  assign o_occ_count = r_count;

endmodule

// File: rtl/rob_multi_ins_queue_dpath.sv
// Storage half of the reorder queue: payload registers written by accepted
// inserts and a read mux selecting the head entry.
module rob_MultiInsDpath #(
  parameter int p_depth    = 8,
  parameter int p_bitwidth = 32,
  parameter int p_num_ins  = 2,
  parameter int p_ptrwidth = $clog2(p_depth)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [p_num_ins-1:0]            i_ins_cpl,
  input  logic [p_num_ins*p_ptrwidth-1:0] i_ins_sn,
  input  logic [p_num_ins*p_bitwidth-1:0] i_ins_data,
  input  logic [p_ptrwidth-1:0]           i_head,
  output logic [p_bitwidth-1:0]           o_head_data
);

  logic [p_bitwidth-1:0] r_data [p_depth];

  // Accepted inserts always target distinct slots, so port order here is moot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < p_depth; s++)
        r_data[s] <= '0;
    end else begin
      for (int s = 0; s < p_depth; s++) begin
        for (int i = 0; i < p_num_ins; i++) begin
          if (i_ins_cpl[i] && (i_ins_sn[i*p_ptrwidth +: p_ptrwidth] == p_ptrwidth'(s)))
            r_data[s] <= i_ins_data[i*p_bitwidth +: p_bitwidth];
        end
      end
    end
  end

  assign o_head_data = r_data[i_head];

endmodule

// File: rtl/rob_multi_ins_queue.sv
// Reorder queue with several out-of-order insert ports and one in-order
// dequeue port at the head.
module rob_multi_ins_queue
  import rob_multi_ins_queue_pkg::*;
#(
  parameter int p_depth    = ROB_DEPTH,
  parameter int p_bitwidth = ROB_BITWIDTH,
  parameter int p_num_ins  = ROB_NUM_INS,
  parameter int p_ptrwidth = $clog2(p_depth)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            deq_front_en,
  output logic                            deq_front_cpl,
  output logic [p_bitwidth-1:0]           deq_front_data,
  output logic [p_ptrwidth-1:0]           deq_front_sn,
  input  logic [p_num_ins-1:0]            ins_en,
  output logic [p_num_ins-1:0]            ins_cpl,
  input  logic [p_num_ins*p_ptrwidth-1:0] ins_sn_in,
  input  logic [p_num_ins*p_bitwidth-1:0] ins_data_in,
  output logic [p_ptrwidth:0]             occ_count
);

  logic [p_num_ins-1:0]  w_ins_cpl;
  logic [p_ptrwidth-1:0] w_head;

  rob_MultiInsCtrlUnit #(
    .p_depth    (p_depth),
    .p_num_ins  (p_num_ins),
    .p_ptrwidth (p_ptrwidth)
  ) u_ctrl (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_flush     (flush),
    .i_deq_en    (deq_front_en),
    .i_ins_en    (ins_en),
    .i_ins_sn    (ins_sn_in),
    .o_ins_cpl   (w_ins_cpl),
    .o_deq_cpl   (deq_front_cpl),
    .o_head      (w_head),
    .o_occ_count (occ_count)
  );

  rob_MultiInsDpath #(
    .p_depth    (p_depth),
    .p_bitwidth (p_bitwidth),
    .p_num_ins  (p_num_ins),
    .p_ptrwidth (p_ptrwidth)
  ) u_dpath (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_ins_cpl   (w_ins_cpl),
    .i_ins_sn    (ins_sn_in),
    .i_ins_data  (ins_data_in),
    .i_head      (w_head),
    .o_head_data (deq_front_data)
  );

  assign ins_cpl      = w_ins_cpl;
  assign deq_front_sn = w_head;

endmodule
